// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and data memory: FIFO drain, load forwarding.
// Optional STORE_BUF_COALESCE_EN merges a store into the youngest same-word entry.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [DATA_W-1:0]        st_data,
  input  logic                     st_byte,
  input  logic                     ld_valid,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic                     ld_byte,
  output logic                     ld_hit,
  output logic [DATA_W-1:0]        ld_data,
  output logic                     ld_stall,
  input  logic                     mem_busy,
  output logic                     mem_DE,
  output logic                     mem_WE,
  output logic [ADDR_W-1:0]        mem_A,
  output logic [DATA_W-1:0]        mem_WD,
  output logic                     mem_byte,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0]  vld_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic              byte_q [DEPTH];
  logic [3:0]        mask_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic drain_fire;
  logic merge_ok;
  logic accept;
  logic push;

  function automatic logic [DATA_W-1:0] lanes(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  assign empty      = (cnt_q == '0);
  assign count      = cnt_q;
  assign drain_fire = rst_n && !empty && !ld_valid && !mem_busy;

  // Lane-aligned store image
  logic [1:0]        st_lane;
  logic [3:0]        st_mask;
  logic [DATA_W-1:0] st_wdata;

  assign st_lane  = st_addr[1:0];
  assign st_mask  = st_byte ? (4'b0001 << st_lane) : 4'b1111;
  assign st_wdata = st_byte
                  ? (DATA_W'(st_data[7:0]) << {st_lane, 3'b000})
                  : st_data;

`ifdef STORE_BUF_COALESCE_EN
  logic [PW-1:0]     yng;
  logic [DATA_W-1:0] mrg_data;
  logic [3:0]        mrg_mask;
  logic              mrg_byte;

  assign yng = tail_q - PW'(1);

  always_comb begin
    merge_ok = 1'b0;
    if (!empty && !(drain_fire && (yng == head_q)) &&
        (addr_q[yng][ADDR_W-1:2] == st_addr[ADDR_W-1:2])) begin
      merge_ok = !st_byte || (mask_q[yng] == 4'hF) ||
                 (byte_q[yng] && (mask_q[yng] == st_mask));
    end
  end

  always_comb begin
    mrg_data = st_wdata;
    mrg_mask = 4'hF;
    mrg_byte = 1'b0;
    if (st_byte) begin
      mrg_data = (data_q[yng] & ~lanes(st_mask)) | st_wdata;
      mrg_mask = mask_q[yng];
      mrg_byte = byte_q[yng];
    end
  end
`else
  assign merge_ok = 1'b0;
`endif

  assign st_ready = rst_n &&
                    ((cnt_q < CW'(DEPTH)) || drain_fire || merge_ok);
  assign accept   = st_valid && st_ready;
  assign push     = accept && !merge_ok;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (drain_fire) head_d = head_q + PW'(1);
    if (push)       tail_d = tail_q + PW'(1);
    if (push && !drain_fire) cnt_d = cnt_q + CW'(1);
    if (!push && drain_fire) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      if (drain_fire) vld_q[head_q] <= 1'b0;
      if (push) begin
        vld_q[tail_q]  <= 1'b1;
        addr_q[tail_q] <= st_addr;
        data_q[tail_q] <= st_wdata;
        byte_q[tail_q] <= st_byte;
        mask_q[tail_q] <= st_mask;
      end
`ifdef STORE_BUF_COALESCE_EN
      else if (accept) begin
        if (!st_byte) addr_q[yng] <= st_addr;
        data_q[yng] <= mrg_data;
        mask_q[yng] <= mrg_mask;
        byte_q[yng] <= mrg_byte;
      end
`endif
    end
  end

  // Drain port always presents the head entry
  logic [DATA_W-1:0] hd_shift;

  assign hd_shift = data_q[head_q] >> {addr_q[head_q][1:0], 3'b000};
  assign mem_DE   = drain_fire;
  assign mem_WE   = drain_fire;
  assign mem_A    = addr_q[head_q];
  assign mem_byte = byte_q[head_q];
  assign mem_WD   = byte_q[head_q]
                  ? {{(DATA_W-8){1'b0}}, hd_shift[7:0]}
                  : data_q[head_q];

  // Scan oldest to youngest so the last match is the youngest
  logic          fwd_found;
  logic [PW-1:0] fwd_idx;
  logic [PW-1:0] scan;

  always_comb begin
    fwd_found = 1'b0;
    fwd_idx   = '0;
    scan      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan = head_q + PW'(i);
      if (vld_q[scan] &&
          (addr_q[scan][ADDR_W-1:2] == ld_addr[ADDR_W-1:2])) begin
        fwd_found = 1'b1;
        fwd_idx   = scan;
      end
    end
  end

  logic [3:0] ld_mask;
  logic       fwd_ok;

  assign ld_mask = 4'b0001 << ld_addr[1:0];
  assign fwd_ok  = ld_byte ? |(mask_q[fwd_idx] & ld_mask)
                           : (mask_q[fwd_idx] == 4'hF);

  always_comb begin
    ld_hit   = 1'b0;
    ld_stall = 1'b0;
    ld_data  = '0;
    if (rst_n && ld_valid && fwd_found) begin
      if (fwd_ok) begin
        ld_hit  = 1'b1;
        ld_data = ld_byte ? (data_q[fwd_idx] & lanes(ld_mask))
                          : data_q[fwd_idx];
      end else begin
        ld_stall = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: drains and load responses checked by a monitor.
// Honours STORE_BUF_COALESCE_EN for the coalescing expectations.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_byte;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_byte;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        ld_stall;
  logic        mem_busy;
  logic        mem_DE;
  logic        mem_WE;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_byte;
  logic        empty;
  logic [2:0]  count;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_byte(st_byte),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_byte(ld_byte),
    .ld_hit(ld_hit), .ld_data(ld_data), .ld_stall(ld_stall),
    .mem_busy(mem_busy), .mem_DE(mem_DE), .mem_WE(mem_WE),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_byte(mem_byte),
    .empty(empty), .count(count)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        b;
  } drn_t;

  typedef struct {
    logic        hit;
    logic        stall;
    logic [31:0] d;
  } ldr_t;

  drn_t dq[$];
  ldr_t lq[$];
  drn_t de;
  ldr_t le;

  int vec = 0;
  int err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_WE) begin
      if (dq.size() == 0) begin
        chk("unexpected drain", 32'd1, 32'd0);
      end else begin
        de = dq.pop_front();
        chk("drain DE", {31'b0, mem_DE}, 32'd1);
        chk("drain addr", mem_A, de.a);
        chk("drain byte", {31'b0, mem_byte}, {31'b0, de.b});
        chk("drain data", de.b ? {24'b0, mem_WD[7:0]} : mem_WD, de.d);
      end
    end
    if (ld_valid) begin
      if (lq.size() == 0) begin
        chk("unexpected load", 32'd1, 32'd0);
      end else begin
        le = lq.pop_front();
        chk("ld_hit", {31'b0, ld_hit}, {31'b0, le.hit});
        chk("ld_stall", {31'b0, ld_stall}, {31'b0, le.stall});
        if (le.hit) chk("ld_data", ld_data, le.d);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d,
                    input logic b);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_byte  = b;
  endtask

  task automatic ld(input logic [31:0] a, input logic b,
                    input logic h, input logic s, input logic [31:0] d);
    ldr_t r;
    r.hit   = h;
    r.stall = s;
    r.d     = d;
    lq.push_back(r);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_byte  = b;
  endtask

  task automatic exp_drain(input logic [31:0] a, input logic [31:0] d,
                           input logic b);
    drn_t r;
    r.a = a;
    r.d = d;
    r.b = b;
    dq.push_back(r);
  endtask

  int n_coal;

  initial begin
    rst_n    = 1'b0;
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    st_byte  = 1'b0;
    ld_valid = 1'b0;
    ld_addr  = '0;
    ld_byte  = 1'b0;
    mem_busy = 1'b1;
`ifdef STORE_BUF_COALESCE_EN
    n_coal = 1;
`else
    n_coal = 2;
`endif
    repeat (2) cyc();
    chk("st_ready in reset", {31'b0, st_ready}, 32'd0);
    chk("mem_WE in reset", {31'b0, mem_WE}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("reset empty", {31'b0, empty}, 32'd1);
    chk("reset st_ready", {31'b0, st_ready}, 32'd1);
    chk("reset count", {29'b0, count}, 32'd0);

    // single word store then drain
    st(32'h100, 32'hDEADBEEF, 1'b0);
    cyc();
    st_valid = 1'b0;
    #1;
    chk("t1 count", {29'b0, count}, 32'd1);
    chk("t1 empty", {31'b0, empty}, 32'd0);
    exp_drain(32'h100, 32'hDEADBEEF, 1'b0);
    mem_busy = 1'b0;
    cyc();
    mem_busy = 1'b1;
    #1;
    chk("t1 empty after drain", {31'b0, empty}, 32'd1);
    chk("t1 mem_WE idle", {31'b0, mem_WE}, 32'd0);

    // fill, then store-with-drain while full
    for (int i = 0; i < 4; i++) begin
      st(32'h10 + 32'(4 * i), 32'(i + 1), 1'b0);
      cyc();
    end
    st_valid = 1'b0;
    #1;
    chk("full count", {29'b0, count}, 32'd4);
    chk("full st_ready", {31'b0, st_ready}, 32'd0);
    st(32'h20, 32'd5, 1'b0);
    mem_busy = 1'b0;
    exp_drain(32'h10, 32'd1, 1'b0);
    #1;
    chk("full+drain st_ready", {31'b0, st_ready}, 32'd1);
    cyc();
    st_valid = 1'b0;
    mem_busy = 1'b1;
    #1;
    chk("full+drain count", {29'b0, count}, 32'd4);
    exp_drain(32'h14, 32'd2, 1'b0);
    exp_drain(32'h18, 32'd3, 1'b0);
    exp_drain(32'h1C, 32'd4, 1'b0);
    exp_drain(32'h20, 32'd5, 1'b0);
    mem_busy = 1'b0;
    repeat (4) cyc();
    mem_busy = 1'b1;
    #1;
    chk("fill empty", {31'b0, empty}, 32'd1);

    // forwarding
    st(32'h200, 32'h11223344, 1'b0);
    cyc();
    st_valid = 1'b0;
    ld(32'h200, 1'b0, 1'b1, 1'b0, 32'h11223344);
    cyc();
    ld(32'h202, 1'b1, 1'b1, 1'b0, 32'h00220000);
    cyc();
    ld_valid = 1'b0;
    exp_drain(32'h200, 32'h11223344, 1'b0);
    mem_busy = 1'b0;
    cyc();
    mem_busy = 1'b1;
    #1;
    chk("fwd empty", {31'b0, empty}, 32'd1);

    // partial coverage stalls
    st(32'h301, 32'h000000AB, 1'b1);
    cyc();
    st_valid = 1'b0;
    ld(32'h300, 1'b0, 1'b0, 1'b1, 32'h0);
    cyc();
    ld(32'h302, 1'b1, 1'b0, 1'b1, 32'h0);
    cyc();
    ld(32'h301, 1'b1, 1'b1, 1'b0, 32'h0000AB00);
    cyc();
    ld_valid = 1'b0;
    exp_drain(32'h301, 32'hAB, 1'b1);
    mem_busy = 1'b0;
    cyc();
    mem_busy = 1'b1;
    ld(32'h300, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc();
    ld_valid = 1'b0;
    #1;
    chk("partial empty", {31'b0, empty}, 32'd1);

    // ordering / coalescing
    st(32'h400, 32'd1, 1'b0);
    cyc();
    st(32'h400, 32'd2, 1'b0);
    cyc();
    st_valid = 1'b0;
    #1;
    chk("order count", {29'b0, count}, 32'(n_coal));
    ld(32'h400, 1'b0, 1'b1, 1'b0, 32'd2);
    cyc();
    ld_valid = 1'b0;
    if (n_coal == 2) exp_drain(32'h400, 32'd1, 1'b0);
    exp_drain(32'h400, 32'd2, 1'b0);
    mem_busy = 1'b0;
    repeat (n_coal) cyc();
    mem_busy = 1'b1;
    #1;
    chk("order empty", {31'b0, empty}, 32'd1);

    // reset with entries pending
    for (int i = 0; i < 3; i++) begin
      st(32'h500 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0);
      cyc();
    end
    st_valid = 1'b0;
    #1;
    chk("pre-reset count", {29'b0, count}, 32'd3);
    rst_n    = 1'b0;
    mem_busy = 1'b0;
    #1;
    chk("reset forces mem_WE", {31'b0, mem_WE}, 32'd0);
    chk("reset forces st_ready", {31'b0, st_ready}, 32'd0);
    cyc();
    rst_n = 1'b1;
    #1;
    chk("mid-reset count", {29'b0, count}, 32'd0);
    chk("mid-reset empty", {31'b0, empty}, 32'd1);
    chk("mid-reset mem_WE", {31'b0, mem_WE}, 32'd0);
    chk("mid-reset st_ready", {31'b0, st_ready}, 32'd1);
    cyc();
    mem_busy = 1'b1;
    cyc();

    chk("drains outstanding", 32'(dq.size()), 32'd0);
    chk("loads outstanding", 32'(lq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
